// File: rtl/memory_stage_unit.sv
// memory_stage_unit: MEM stage behind the EX/MEM buffer.
// Performs loads and stores against an internal 16-bit data/stack memory. A 32-bit
// PC push or pop takes two memory words, so a two-state FSM handles the second word.
// The FSM asserts Stall for one cycle while it does this.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   Data, Address        EX/MEM data and word address (only Address[ADDR_WIDTH-1:0] used)
//   MR, MW               memory read / write (MW wins when both set)
//   WB, WB_Address       write-back request and destination register
//   Stack_PC/Stack_Flags 32-bit PC push/pop, or flags push/pop (Stack_PC wins)
//   Final_Flags          NF|CF|ZF to push
//   Stall                combinational hold request to upstream stages
//   WB_Out, WB_Address_Out, Result     registered MEM/WB outputs
//   Flags_Out/Flags_Valid              popped flags and their one-cycle valid pulse
//   PC_Out/PC_Valid                    popped PC and its one-cycle redirect pulse
//   SP_Extra_Dec/SP_Extra_Inc          one-cycle pulse for the extra stack pointer step
module memory_stage_unit #(
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned INIT_SP_TOP = 2**ADDR_WIDTH - 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Data,
  input  logic [31:0] Address,
  input  logic        MR,
  input  logic        MW,
  input  logic        WB,
  input  logic [2:0]  WB_Address,
  input  logic        Stack_PC,
  input  logic        Stack_Flags,
  input  logic [2:0]  Final_Flags,
  output logic        Stall,
  output logic        WB_Out,
  output logic [2:0]  WB_Address_Out,
  output logic [15:0] Result,
  output logic [2:0]  Flags_Out,
  output logic        Flags_Valid,
  output logic [31:0] PC_Out,
  output logic        PC_Valid,
  output logic        SP_Extra_Dec,
  output logic        SP_Extra_Inc
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam int unsigned AW    = ADDR_WIDTH;

  typedef enum logic {S_IDLE, S_SECOND} state_t;

  logic [15:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic          pop_q, pop_d;
  logic [AW-1:0] addr2_q, addr2_d;
  logic [15:0]   low_q, low_d;
  logic          wb_q, wb_d;
  logic [2:0]    wba_q, wba_d;
  logic [15:0]   result_q, result_d;
  logic [2:0]    flags_q, flags_d;
  logic          flags_v_q, flags_v_d;
  logic [31:0]   pc_q, pc_d;
  logic          pc_v_q, pc_v_d;
  logic          dec_q, dec_d;
  logic          inc_q, inc_d;

  logic [AW-1:0] a_c;
  logic [15:0]   rd_c;
  logic          stall_c;
  logic          mem_we_c;
  logic [AW-1:0] mem_wa_c;
  logic [15:0]   mem_wd_c;

  // The upper address bits and the stack-top parameter carry no logic here.
  logic unused_c;
  assign unused_c = ^{Address[31:AW], 32'(INIT_SP_TOP)};

  assign a_c  = Address[AW-1:0];
  assign rd_c = mem[a_c];

  // Next-state, memory-write and output computation.
  always_comb begin
    state_d   = state_q;
    pop_d     = pop_q;
    addr2_d   = addr2_q;
    low_d     = low_q;
    wb_d      = 1'b0;
    wba_d     = wba_q;
    result_d  = result_q;
    flags_d   = flags_q;
    flags_v_d = 1'b0;
    pc_d      = pc_q;
    pc_v_d    = 1'b0;
    dec_d     = 1'b0;
    inc_d     = 1'b0;
    stall_c   = 1'b0;
    mem_we_c  = 1'b0;
    mem_wa_c  = a_c;
    mem_wd_c  = Data[15:0];

    case (state_q)
      S_IDLE: begin
        if (MW) begin
          mem_we_c = 1'b1;
          if (Stack_PC) begin
            // High half goes to A now, low half to A-1 in the second cycle.
            stall_c  = 1'b1;
            mem_wd_c = Data[31:16];
            addr2_d  = a_c - AW'(1);
            low_d    = Data[15:0];
            pop_d    = 1'b0;
            state_d  = S_SECOND;
          end else if (Stack_Flags) begin
            mem_wd_c = {13'b0, Final_Flags};
          end
        end else if (MR) begin
          if (Stack_PC) begin
            // Low half is at A; the high half is read from A+1 next cycle.
            stall_c = 1'b1;
            low_d   = rd_c;
            addr2_d = a_c + AW'(1);
            pop_d   = 1'b1;
            state_d = S_SECOND;
          end else if (Stack_Flags) begin
            flags_d   = rd_c[2:0];
            flags_v_d = 1'b1;
          end else begin
            result_d = rd_c;
            wb_d     = WB;
            wba_d    = WB_Address;
          end
        end else begin
          result_d = Data[15:0];
          wb_d     = WB;
          wba_d    = WB_Address;
        end
      end
      S_SECOND: begin
        // Inputs are still held by upstream here, so they are ignored.
        state_d = S_IDLE;
        if (pop_q) begin
          pc_d   = {mem[addr2_q], low_q};
          pc_v_d = 1'b1;
          inc_d  = 1'b1;
        end else begin
          mem_we_c = 1'b1;
          mem_wa_c = addr2_q;
          mem_wd_c = low_q;
          dec_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset blocks the write, which aborts the second word of a push in progress.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we_c) mem[mem_wa_c] <= mem_wd_c;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pop_q     <= 1'b0;
      addr2_q   <= '0;
      low_q     <= '0;
      wb_q      <= 1'b0;
      wba_q     <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      flags_v_q <= 1'b0;
      pc_q      <= '0;
      pc_v_q    <= 1'b0;
      dec_q     <= 1'b0;
      inc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pop_q     <= pop_d;
      addr2_q   <= addr2_d;
      low_q     <= low_d;
      wb_q      <= wb_d;
      wba_q     <= wba_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      flags_v_q <= flags_v_d;
      pc_q      <= pc_d;
      pc_v_q    <= pc_v_d;
      dec_q     <= dec_d;
      inc_q     <= inc_d;
    end
  end

  assign Stall          = stall_c & rst_n;
  assign WB_Out         = wb_q;
  assign WB_Address_Out = wba_q;
  assign Result         = result_q;
  assign Flags_Out      = flags_q;
  assign Flags_Valid    = flags_v_q;
  assign PC_Out         = pc_q;
  assign PC_Valid       = pc_v_q;
  assign SP_Extra_Dec   = dec_q;
  assign SP_Extra_Inc   = inc_q;

endmodule

// File: tb/tb_memory_stage_unit.sv
// Scoreboard bench for memory_stage_unit: expected write-back results, popped flags
// and popped PCs are queued when a request is driven and retired by a monitor.
module tb_memory_stage_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Data, Address;
  logic        MR, MW, WB, Stack_PC, Stack_Flags;
  logic [2:0]  WB_Address, Final_Flags;
  logic        Stall, WB_Out, Flags_Valid, PC_Valid, SP_Extra_Dec, SP_Extra_Inc;
  logic [2:0]  WB_Address_Out, Flags_Out;
  logic [15:0] Result;
  logic [31:0] PC_Out;

  memory_stage_unit #(.ADDR_WIDTH(11)) dut (
    .clk(clk), .rst_n(rst_n), .Data(Data), .Address(Address), .MR(MR), .MW(MW),
    .WB(WB), .WB_Address(WB_Address), .Stack_PC(Stack_PC), .Stack_Flags(Stack_Flags),
    .Final_Flags(Final_Flags), .Stall(Stall), .WB_Out(WB_Out),
    .WB_Address_Out(WB_Address_Out), .Result(Result), .Flags_Out(Flags_Out),
    .Flags_Valid(Flags_Valid), .PC_Out(PC_Out), .PC_Valid(PC_Valid),
    .SP_Extra_Dec(SP_Extra_Dec), .SP_Extra_Inc(SP_Extra_Inc)
  );

  always #5 clk = ~clk;

  logic [18:0] q_res   [$];
  logic [2:0]  q_flags [$];
  logic [31:0] q_pc    [$];
  logic [15:0] mdl     [int];
  int n_checks = 0;
  int n_fail   = 0;
  int n_dec    = 0;
  int n_inc    = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: retire scoreboard entries when the DUT presents a result.
  always @(negedge clk) begin : monitor
    logic [18:0] er;
    logic [2:0]  ef;
    logic [31:0] ep;
    if (SP_Extra_Dec === 1'b1) n_dec++;
    if (SP_Extra_Inc === 1'b1) n_inc++;
    if (WB_Out === 1'b1) begin
      if (q_res.size() == 0) check_eq("wb_unexpected", 32'(WB_Out), 32'd0);
      else begin
        er = q_res.pop_front();
        check_eq("wb_result", {13'b0, WB_Address_Out, Result}, {13'b0, er});
      end
    end
    if (Flags_Valid === 1'b1) begin
      if (q_flags.size() == 0) check_eq("flags_unexpected", 32'(Flags_Valid), 32'd0);
      else begin
        ef = q_flags.pop_front();
        check_eq("flags_out", 32'(Flags_Out), 32'(ef));
      end
    end
    if (PC_Valid === 1'b1) begin
      if (q_pc.size() == 0) check_eq("pc_unexpected", 32'(PC_Valid), 32'd0);
      else begin
        ep = q_pc.pop_front();
        check_eq("pc_out", PC_Out, ep);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    MR = 0; MW = 0; WB = 0; Stack_PC = 0; Stack_Flags = 0;
    Data = '0; Address = '0; WB_Address = '0; Final_Flags = '0;
  endtask

  function automatic logic [10:0] wrap(input int v);
    return 11'(v);
  endfunction

  task automatic do_store(input logic [10:0] a, input logic [15:0] d);
    idle_in(); MW = 1; Address = 32'(a); Data = {16'hFFFF, d};
    mdl[int'(a)] = d;
    step(); idle_in();
  endtask

  task automatic do_load(input logic [10:0] a, input logic [2:0] wba);
    idle_in(); MR = 1; WB = 1; WB_Address = wba; Address = 32'(a);
    q_res.push_back({wba, mdl[int'(a)]});
    step(); idle_in();
  endtask

  task automatic do_pass(input logic [31:0] d, input logic [2:0] wba);
    idle_in(); WB = 1; WB_Address = wba; Data = d;
    q_res.push_back({wba, d[15:0]});
    step(); idle_in();
  endtask

  task automatic do_pc_push(input logic [10:0] a, input logic [31:0] d);
    idle_in(); MW = 1; Stack_PC = 1; Address = 32'(a); Data = d;
    #1 check_eq("push_stall_c1", 32'(Stall), 32'd1);
    mdl[int'(a)] = d[31:16];
    mdl[int'(wrap(int'(a) - 1))] = d[15:0];
    step();
    check_eq("push_stall_c2", 32'(Stall), 32'd0);
    step(); idle_in();
  endtask

  task automatic do_pc_pop(input logic [10:0] a);
    idle_in(); MR = 1; Stack_PC = 1; Address = 32'(a);
    #1 check_eq("pop_stall_c1", 32'(Stall), 32'd1);
    q_pc.push_back({mdl[int'(wrap(int'(a) + 1))], mdl[int'(a)]});
    step();
    check_eq("pop_stall_c2", 32'(Stall), 32'd0);
    step(); idle_in();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_data"}, {Result, 13'b0, WB_Address_Out}, 32'd0);
    check_eq({tag, "_pc"}, PC_Out, 32'd0);
    check_eq({tag, "_ctl"}, {24'b0, WB_Out, Flags_Out, Flags_Valid, PC_Valid, SP_Extra_Dec, SP_Extra_Inc},
             32'd0);
    check_eq({tag, "_stall"}, 32'(Stall), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [15:0] rv;
    int dec_before;
    idle_in();
    // Reset with a PC-push request presented.
    rst_n = 0; MW = 1; Stack_PC = 1; Address = 32'd5; Data = 32'hBEEFBEEF;
    step(); step();
    check_all_zero("reset");
    rst_n = 1; idle_in();

    // Store then load back-to-back.
    do_store(11'd5, 16'h1234);
    do_load(11'd5, 3'd3);
    do_pass(32'h5555_A5A5, 3'd6);
    do_pass(32'h0000_0001, 3'd1);

    for (int i = 0; i < 4; i++) begin
      rv = 16'($urandom);
      do_store(wrap(i * 37 + 9), rv);
      do_load(wrap(i * 37 + 9), 3'(i + 2));
    end

    // MR and MW together: the write wins and no write-back appears.
    idle_in(); MR = 1; MW = 1; WB = 1; WB_Address = 3'd7; Address = 32'd9; Data = 32'h0000_7777;
    mdl[9] = 16'h7777;
    step(); idle_in();
    do_load(11'd9, 3'd4);

    // Reset with a store presented must not write memory.
    rst_n = 0; MW = 1; Address = 32'd5; Data = 32'h0000_DEAD;
    step(); step();
    rst_n = 1; idle_in();
    do_load(11'd5, 3'd2);

    // PC push at top of memory.
    do_pc_push(11'h7FF, 32'hABCD_0042);
    step();
    check_eq("push_dec_count", 32'(n_dec), 32'd1);
    do_load(11'h7FF, 3'd1);
    do_load(11'h7FE, 3'd2);

    // PC pop whose high word wraps to address 0.
    do_store(11'h7FF, 16'h0000);
    do_store(11'h000, 16'h0001);
    do_pc_pop(11'h7FF);
    step();
    check_eq("pop_inc_count", 32'(n_inc), 32'd1);
    check_eq("pop_pc_value", PC_Out, 32'h0001_0000);

    // Flags round trip; the pop must not request write-back.
    idle_in(); MW = 1; Stack_Flags = 1; Final_Flags = 3'b101; Address = 32'h7FD;
    mdl[32'h7FD] = 16'h0005;
    step(); idle_in();
    MR = 1; Stack_Flags = 1; WB = 1; WB_Address = 3'd5; Address = 32'h7FD;
    q_flags.push_back(mdl[32'h7FD][2:0]);
    step(); idle_in();
    check_eq("flags_wb_out", 32'(WB_Out), 32'd0);
    check_eq("flags_valid", 32'(Flags_Valid), 32'd1);
    step();
    check_eq("flags_valid_pulse", 32'(Flags_Valid), 32'd0);

    // Reset during the second cycle of a push aborts the low-word write.
    do_store(11'h0FF, 16'h5A5A);
    dec_before = n_dec;
    idle_in(); MW = 1; Stack_PC = 1; Address = 32'h100; Data = 32'h1111_2222;
    mdl[32'h100] = 16'h1111;
    step();
    rst_n = 0;
    step();
    rst_n = 1; idle_in();
    check_all_zero("rst_second");
    step();
    check_eq("rst_second_dec", 32'(n_dec), 32'(dec_before));
    do_load(11'h0FF, 3'd3);
    do_load(11'h100, 3'd4);

    // Drain and confirm every expectation was retired.
    step(); step();
    check_eq("q_res_empty", 32'(q_res.size()), 32'd0);
    check_eq("q_flags_empty", 32'(q_flags.size()), 32'd0);
    check_eq("q_pc_empty", 32'(q_pc.size()), 32'd0);
    check_eq("final_dec_count", 32'(n_dec), 32'd1);
    check_eq("final_inc_count", 32'(n_inc), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_stage_unit.md
Name: memory_stage_unit

Overview:
- Consumer side of the EX/MEM buffer: takes the execution stage's Data, Address, control and flag outputs, and performs the memory access against an internal 16-bit-wide data/stack memory.
- Produces the registered MEM/WB outputs, the restored-flags path back to the execution stage, and the popped-PC redirect to fetch.
- 32-bit PC push/pop takes two memory words. A two-state FSM sequences these and stalls upstream for one cycle.

Parameters:
ADDR_WIDTH, 11, word-address bits; memory depth = 2**ADDR_WIDTH 16-bit words
INIT_SP_TOP, 2**ADDR_WIDTH-1, documentation only; top-of-stack address the stack pointer starts from (no logic here)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
Data  in  32  EX/MEM data (PC in [31:0] for PC push, otherwise [15:0] used)
Address  in  32  EX/MEM word address; only [ADDR_WIDTH-1:0] used
MR  in  1  memory read
MW  in  1  memory write
WB  in  1  register write-back request
WB_Address  in  3  destination register
Stack_PC  in  1  access is a 32-bit PC push/pop
Stack_Flags  in  1  access is a flags push/pop
Final_Flags  in  3  NF|CF|ZF to push
Stall  out  1  hold EX/MEM buffer and earlier stages this cycle
WB_Out  out  1  registered write-back enable
WB_Address_Out  out  3  registered destination
Result  out  16  registered load data or pass-through Data[15:0]
Flags_Out  out  3  registered popped flags NF|CF|ZF
Flags_Valid  out  1  one-cycle pulse, Flags_Out valid
PC_Out  out  32  registered popped PC
PC_Valid  out  1  one-cycle pulse, PC_Out valid (fetch redirect)
SP_Extra_Dec  out  1  one-cycle pulse: stack pointer must decrement once more (second push word)
SP_Extra_Inc  out  1  one-cycle pulse: stack pointer must increment once more (second pop word)

Behaviour:
- Reset (rst_n=0 at edge):
  - FSM to IDLE.
  - All registered outputs to 0; Stall=0.
  - No memory write occurs in that cycle.
  - Memory contents are not cleared.
- Address: A = Address[ADDR_WIDTH-1:0]. A-1 and A+1 wrap modulo 2**ADDR_WIDTH.
- Priority when MR and MW are both 1: MW wins and MR is ignored. Stack_PC has priority over Stack_Flags.
- IDLE, single-word ops (1-cycle latency; outputs update at the edge ending the request cycle):
  - MW & !Stack_PC & !Stack_Flags: mem[A] <= Data[15:0].
  - MW & Stack_Flags: mem[A] <= {13'b0, Final_Flags}.
  - MR & !Stack_PC & !Stack_Flags: Result <= mem[A]; WB_Out <= WB; WB_Address_Out <= WB_Address.
  - MR & Stack_Flags: Flags_Out <= mem[A][2:0]; Flags_Valid <= 1; WB_Out <= 0.
  - Neither MR nor MW: Result <= Data[15:0]; WB_Out <= WB; WB_Address_Out <= WB_Address (ALU/IN pass-through).
- PC push (IDLE, MW & Stack_PC):
  - Cycle 1: Stall=1 (combinational); mem[A] <= Data[31:16]; latch A-1 and Data[15:0]; go to SECOND.
  - Cycle 2 (SECOND): Stall=0; mem[A-1] <= latched low word; SP_Extra_Dec pulse; WB_Out <= 0; back to IDLE.
- PC pop (IDLE, MR & Stack_PC):
  - Cycle 1: Stall=1; latch mem[A] as PC low; latch A+1; go to SECOND.
  - Cycle 2: PC_Out <= {mem[A+1], latched low}; PC_Valid <= 1; SP_Extra_Inc pulse; back to IDLE.
- SECOND state:
  - Inputs are ignored, because upstream held them during Stall.
  - A new request is accepted only from IDLE.
- Pulse outputs (Flags_Valid, PC_Valid, SP_Extra_Dec, SP_Extra_Inc) are high for exactly one cycle. They default to 0 whenever not set.
- Back-to-back operations: a new request is accepted in the cycle after the FSM returns to IDLE. A load immediately after a store to the same address returns the stored value (write then read in successive cycles).
- Reset mid-operation: if rst_n=0 while in SECOND, the second write/read is aborted. The second word is not written, and PC_Valid and SP_Extra_* stay 0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with MW=1 → all outputs 0, Stall=0, and mem at the presented A is unchanged.
- Store/load: MW, A=5, Data=0x00001234; next cycle MR, WB=1, WB_Address=3, A=5 → one cycle later Result=0x1234, WB_Out=1, WB_Address_Out=3.
- PC push: MW, Stack_PC, A=0x7FF, Data=0xABCD0042 → Stall=1 in cycle 1 only; mem[0x7FF]=0xABCD; mem[0x7FE]=0x0042; SP_Extra_Dec pulses in cycle 2.
- PC pop with wrap: preload mem[0x7FF]=0x0000 and mem[0x000]=0x0001 (low word at 0x7FF); MR, Stack_PC, A=0x7FF → PC_Out=0x00010000, PC_Valid and SP_Extra_Inc pulse once, Stall=1 only in cycle 1.
- Flags round trip: MW, Stack_Flags, Final_Flags=3'b101, A=0x7FD; then MR, Stack_Flags, A=0x7FD → Flags_Out=3'b101, Flags_Valid pulses once, WB_Out=0.
- Reset in SECOND during PC push at A=0x100 → mem[0x0FF] unchanged, FSM IDLE, no SP_Extra_Dec, all outputs 0 next cycle.
